waterfall_buffer: RTL and testbench
===================================

# waterfall_buffer

Circular row store for the spectrogram waterfall. Accepts one row of spectrum magnitudes per frame from the FFT/magnitude stage through a valid/ready stream, and serves per-pixel magnitudes to `color_map` when addressed by `rd_row` from `video_handler` and `pixel_x` from `video_timing`. Rows are double-buffered against the display: a new row becomes visible only at a vsync edge, so the picture never tears. The newest committed row is always `rd_row = 0`.

## Interface
- `ROWS`, 180: number of displayed waterfall rows.
- `COLS`, 512: bins per row. Must be a power of two and ≤ 1024.
- `DATA_W`, 8: magnitude width.

- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_W  magnitude bin.
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  last bin of the row.
- `s_ready`  out  1  buffer accepts a bin.
- `vsync`  in  1  from `video_timing`; active-high.
- `pixel_x`  in  10  column being drawn.
- `rd_row`  in  9  row offset from `video_handler`; 0 is the newest row.
- `rd_data`  out  DATA_W  magnitude to `color_map`.
- `frame_err`  out  1  one-cycle pulse when a row is discarded.
- `freeze`  in  1  present only with `WATERFALL_FREEZE_EN`.

## Operation
- Storage holds `ROWS+1` physical rows of `COLS` words in a single simple-dual-port RAM.
  - Address is `{phys_row, col[log2(COLS)-1:0]}`.
  - The write row is always the one physical row that is not displayed.
- Registers:
  - `head`: physical row that is displayed as `rd_row = 0`.
  - `wr_row`: physical row being written.
  - `wr_col`: column counter.
  - `vs_q`: previous `vsync`, used for rising-edge detection.
- State machine:
  - CLEAR:
    - Entered on reset.
    - Writes zero to every address, one per cycle, for `(ROWS+1)*COLS` cycles.
    - `s_ready = 0`; `rd_data` is forced to 0.
    - Goes to FILL after the last address is written.
  - FILL:
    - `s_ready = 1`. Each `s_valid` cycle writes `s_data` at (`wr_row`, `wr_col`).
    - On a mid-row bin (`wr_col ≠ COLS-1`): if `s_last = 0`, increment `wr_col`.
    - On the final bin (`wr_col = COLS-1`): if `s_last = 1`, set `wr_col = 0` and go to PENDING.
    - Framing error is a mismatch, either:
      - `s_last = 1` while `wr_col ≠ COLS-1`, or
      - `s_last = 0` while `wr_col = COLS-1`.
    - On a framing error: `wr_col = 0`, stay in FILL, pulse `frame_err` the next cycle. Partially written data is left in place and is overwritten by the next row.
  - PENDING:
    - `s_ready = 0`.
    - On a `vsync` rising edge: `head ← wr_row`, `wr_row ← (wr_row+1) mod (ROWS+1)`, go to FILL.
- Read path:
  - `phys_row = (head + ROWS+1 − rd_row) mod (ROWS+1)`, computed without a divider (single conditional subtract).
  - If `rd_row ≥ ROWS` or `pixel_x ≥ COLS`, `rd_data` is 0.
- Row throughput is at most one row per frame. The upstream stage must hold off on `s_ready`.

## Timing
- Reset values: `s_ready = 0`, `rd_data = 0`, `frame_err = 0`, `head = 0`, `wr_row = 1`, `wr_col = 0`, state CLEAR, `vs_q = 0`.
- Read latency is exactly 2 cycles:
  - cycle 1: `phys_row` and range flags registered;
  - cycle 2: RAM output registered to `rd_data`.
  - This latency is fixed regardless of state.
- `head` changes only on the cycle after a detected `vsync` edge, so it is stable throughout the active region.
- Row completion and a `vsync` edge in the same cycle: the edge is ignored and the commit waits for the next edge.
- A `vsync` edge during CLEAR or FILL has no effect.
- `rst_n` asserted mid-row or mid-clear: all state returns to reset values immediately and CLEAR restarts from address 0.
- `head` wraps from `ROWS` to 0; `wr_row` wraps likewise.

## Configuration
- `WATERFALL_FREEZE_EN`:
  - Defined: adds the `freeze` input. While `freeze = 1`, `vsync` edges do not commit in PENDING, so the display holds and the writer is stalled by `s_ready = 0`. Commits resume on the first edge after `freeze` falls.
  - Undefined: no `freeze` port; commits are unconditional.

## Test plan
All scenarios use `ROWS=4`, `COLS=8`, `DATA_W=8`.
- **Reset and clear:** release `rst_n`.
  - Expect `s_ready = 0` for exactly 40 cycles, then 1.
  - Reads of any row/column afterwards return 0.
- **Single row commit:** stream 8 bins 0x10..0x17 with `s_last` on the 8th bin.
  - Expect `s_ready = 0`, and `rd_row = 0` still reads 0.
  - After a `vsync` edge, `rd_row = 0`, `pixel_x = 3` returns 0x13 two cycles later.
- **Scroll and wrap:** commit 6 rows whose fill values are 1..6, one per frame.
  - `rd_row` 0..3 returns 6, 5, 4, 3.
  - `rd_row = 4` and `pixel_x = 8` each return 0.
- **Framing errors:**
  - `s_last` on the 5th bin: `frame_err` pulses once, no commit at the next `vsync`, and a following good row commits normally.
  - No `s_last` on the 8th bin: same response.
- **Simultaneous events:** final bin accepted in the same cycle as the `vsync` rising edge.
  - The display is unchanged until the following edge.
- **Reset mid-row and freeze:**
  - Assert `rst_n` low after 3 bins: CLEAR restarts and all reads return 0.
  - With the macro defined, `freeze = 1` across two `vsync` edges: no commit occurs and `s_ready` stays 0.

Source files
------------

// File: rtl/waterfall_buffer.sv
// ============================================================================
// Module      : waterfall_buffer
// Description : Circular spectrogram row store with a 2-cycle read path and
//               vsync-synchronous row commit. The optional display freeze is
//               enabled by defining WATERFALL_FREEZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module waterfall_buffer #(
    parameter int ROWS   = 180,
    parameter int COLS   = 512,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              vsync,
`ifdef WATERFALL_FREEZE_EN
    input  logic              freeze,
`endif
    input  logic [9:0]        pixel_x,
    input  logic [8:0]        rd_row,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_err
);

    localparam int PROWS = ROWS + 1;
    localparam int RW    = $clog2(PROWS);
    localparam int CW    = $clog2(COLS);
    localparam int AW    = RW + CW;
    localparam int DEPTH = PROWS * COLS;
    localparam int XW    = ((RW > 9) ? RW : 9) + 1;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_FILL    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [RW-1:0]     head_q, head_d;
    logic [RW-1:0]     wr_row_q, wr_row_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic              vs_q, vs_d;
    logic              frame_err_q, frame_err_d;
    logic [RW-1:0]     phys_row_q, phys_row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              w_commit;
    logic              w_last_col;
    logic [XW-1:0]     w_rd_ext;
    logic [XW-1:0]     w_head_ext;

`ifdef WATERFALL_FREEZE_EN
    assign w_commit = vsync & ~vs_q & ~freeze;
`else
    assign w_commit = vsync & ~vs_q;
`endif

    assign w_last_col = (wr_col_q == CW'(COLS - 1));
    assign s_ready    = (state_q == ST_FILL);
    assign rd_data    = rd_data_q;
    assign frame_err  = frame_err_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        clr_addr_d  = clr_addr_q;
        vs_d        = vsync;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = {wr_row_q, wr_col_q};
        mem_wdata   = s_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    clr_addr_d = '0;
                    state_d    = ST_FILL;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            ST_FILL: begin
                if (s_valid) begin
                    mem_we = 1'b1;
                    // s_last must coincide exactly with the final column
                    if (s_last == w_last_col) begin
                        if (w_last_col) begin
                            wr_col_d = '0;
                            state_d  = ST_PENDING;
                        end else begin
                            wr_col_d = wr_col_q + CW'(1);
                        end
                    end else begin
                        wr_col_d    = '0;
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (w_commit) begin
                    head_d   = wr_row_q;
                    wr_row_d = (wr_row_q == RW'(ROWS)) ? '0 : wr_row_q + RW'(1);
                    state_d  = ST_FILL;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Read stage 1: age offset to physical row with one conditional wrap.
    always_comb begin
        w_rd_ext   = XW'(rd_row);
        w_head_ext = XW'(head_q);
        oor_d      = (w_rd_ext >= XW'(ROWS)) || ({1'b0, pixel_x} >= 11'(COLS));
        col_d      = pixel_x[CW-1:0];
        if (oor_d) begin
            phys_row_d = '0;
        end else if (w_rd_ext > w_head_ext) begin
            phys_row_d = RW'(w_head_ext + XW'(PROWS) - w_rd_ext);
        end else begin
            phys_row_d = RW'(w_head_ext - w_rd_ext);
        end
    end

    always_comb begin
        rd_data_d = mem[{phys_row_q, col_q}];
        if (oor_q || (state_q == ST_CLEAR)) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            head_q      <= '0;
            wr_row_q    <= RW'(1);
            wr_col_q    <= '0;
            clr_addr_q  <= '0;
            vs_q        <= 1'b0;
            frame_err_q <= 1'b0;
            phys_row_q  <= '0;
            col_q       <= '0;
            oor_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            clr_addr_q  <= clr_addr_d;
            vs_q        <= vs_d;
            frame_err_q <= frame_err_d;
            phys_row_q  <= phys_row_d;
            col_q       <= col_d;
            oor_q       <= oor_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_waterfall_buffer.sv
// ============================================================================
// Module      : tb_waterfall_buffer
// Description : Directed, table-driven bench for waterfall_buffer (ROWS=4,
//               COLS=8). Exercises WATERFALL_FREEZE_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_waterfall_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       vsync;
`ifdef WATERFALL_FREEZE_EN
    logic       freeze;
`endif
    logic [9:0] pixel_x;
    logic [8:0] rd_row;
    logic [7:0] rd_data;
    logic       frame_err;

    int nvec;
    int nerr;
    int fe_count;

    typedef struct {
        int         phase;
        logic [8:0] row;
        logic [9:0] px;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[$];

    waterfall_buffer #(.ROWS(4), .COLS(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .vsync    (vsync),
`ifdef WATERFALL_FREEZE_EN
        .freeze   (freeze),
`endif
        .pixel_x  (pixel_x),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input int p, input int r, input int x, input int e);
        rd_vec_t v;
        v.phase = p;
        v.row   = 9'(r);
        v.px    = 10'(x);
        v.exp   = 8'(e);
        tbl.push_back(v);
    endtask

    // Inputs change right after the first capture edge to pin the latency at 2.
    task automatic read_check(input int p, input int idx, input logic [8:0] r,
                              input logic [9:0] x, input logic [7:0] e);
        string nm;
        @(negedge clk);
        rd_row  = r;
        pixel_x = x;
        @(posedge clk);
        @(negedge clk);
        rd_row  = 9'd7;
        pixel_x = 10'd0;
        @(posedge clk);
        @(negedge clk);
        nm = $sformatf("read phase%0d[%0d] row=%0d px=%0d", p, idx, r, x);
        check(nm, int'(rd_data), int'(e));
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].phase == p) read_check(p, i, tbl[i].row, tbl[i].px, tbl[i].exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("s_ready wait timeout", 0, 1);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] base, input logic [7:0] step,
                            input int nbins, input int lastpos);
        for (int i = 0; i < nbins; i++) begin
            push(base + 8'(step * i), (i == lastpos));
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_clear(input string name);
        int cyc;
        cyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (s_ready) break;
        end
        check(name, cyc, 40);
    endtask

    initial begin
        int fe0;
        nvec = 0; nerr = 0; fe_count = 0;
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        vsync = 1'b0; pixel_x = '0; rd_row = '0;
`ifdef WATERFALL_FREEZE_EN
        freeze = 1'b0;
`endif
        // phase 0: after clear
        addv(0, 0, 0, 0);    addv(0, 3, 7, 0);    addv(0, 4, 0, 0);    addv(0, 0, 8, 0);
        // phase 1/2: single row before and after commit
        addv(1, 0, 3, 0);
        addv(2, 0, 3, 8'h13); addv(2, 0, 0, 8'h10); addv(2, 0, 7, 8'h17); addv(2, 1, 3, 0);
        // phase 3: scroll and wrap
        addv(3, 0, 0, 6);    addv(3, 1, 5, 5);    addv(3, 2, 2, 4);    addv(3, 3, 7, 3);
        addv(3, 4, 0, 0);    addv(3, 0, 8, 0);    addv(3, 3, 8, 0);
        // phases 4-7: framing errors
        addv(4, 0, 4, 6);    addv(4, 1, 4, 5);
        addv(5, 0, 2, 8'h77); addv(5, 1, 2, 6);
        addv(6, 0, 1, 8'h77);
        addv(7, 0, 1, 8'h88); addv(7, 1, 1, 8'h77); addv(7, 2, 1, 6);
        // phases 8/9: last bin together with vsync edge
        addv(8, 0, 1, 8'h88);
        addv(9, 0, 1, 8'h99); addv(9, 1, 1, 8'h88);
        // phase 10: after mid-row reset
        addv(10, 0, 1, 0);   addv(10, 1, 1, 0);   addv(10, 2, 3, 0);
        // phases 11/12: freeze
        addv(11, 0, 1, 0);
        addv(12, 0, 1, 8'h33);

        repeat (3) @(negedge clk);
        check("reset s_ready", int'(s_ready), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset frame_err", int'(frame_err), 0);
        wait_clear("clear cycles");
        run_phase(0);

        send_row(8'h10, 8'h01, 8, 7);
        @(negedge clk);
        check("pending s_ready", int'(s_ready), 0);
        run_phase(1);
        vs_pulse();
        run_phase(2);

        for (int v = 1; v <= 6; v++) begin
            send_row(8'(v), 8'h00, 8, 7);
            vs_pulse();
        end
        run_phase(3);

        fe0 = fe_count;
        send_row(8'hA0, 8'h01, 5, 4);
        repeat (2) @(negedge clk);
        check("early s_last frame_err pulses", fe_count - fe0, 1);
        check("early s_last stays in fill", int'(s_ready), 1);
        vs_pulse();
        run_phase(4);
        send_row(8'h77, 8'h00, 8, 7);
        vs_pulse();
        run_phase(5);

        fe0 = fe_count;
        send_row(8'hB0, 8'h01, 8, 99);
        repeat (2) @(negedge clk);
        check("missing s_last frame_err pulses", fe_count - fe0, 1);
        vs_pulse();
        run_phase(6);
        send_row(8'h88, 8'h00, 8, 7);
        vs_pulse();
        run_phase(7);

        send_row(8'h99, 8'h00, 7, 99);
        @(negedge clk);
        s_data = 8'h99; s_valid = 1'b1; s_last = 1'b1; vsync = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        check("simultaneous s_ready", int'(s_ready), 0);
        run_phase(8);
        vs_pulse();
        run_phase(9);

        send_row(8'h55, 8'h00, 3, 99);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-row reset s_ready", int'(s_ready), 0);
        check("mid-row reset rd_data", int'(rd_data), 0);
        repeat (2) @(negedge clk);
        wait_clear("re-clear cycles");
        run_phase(10);

`ifdef WATERFALL_FREEZE_EN
        freeze = 1'b1;
        send_row(8'h33, 8'h00, 8, 7);
        vs_pulse();
        vs_pulse();
        check("freeze s_ready", int'(s_ready), 0);
        run_phase(11);
        freeze = 1'b0;
        vs_pulse();
        run_phase(12);
`endif

        check("total frame_err pulses", fe_count, 2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
